// File: rtl/pipelined_alu_bank.sv
// Two-stage ALU: operands are registered, evaluated combinationally, then queued
// with their tag in a result FIFO that the consumer drains under valid/ready.
module pipelined_alu_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic [5:0]            opcode,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic [3:0]            flags,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic                  illegal
);

   localparam int SHW = $clog2(DATA_WIDTH);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   typedef enum logic [5:0] {
      OP_ADD = 6'b00_0000,
      OP_SUB = 6'b00_0001,
      OP_INC = 6'b00_0010,
      OP_DEC = 6'b00_0011,
      OP_NEG = 6'b00_0100,
      OP_AND = 6'b01_0000,
      OP_OR  = 6'b01_0001,
      OP_XOR = 6'b01_0010,
      OP_NOT = 6'b01_0011,
      OP_SHL = 6'b01_0100,
      OP_SHR = 6'b01_0101,
      OP_SRA = 6'b01_0110
   } opcode_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic [3:0]            flags;
      logic [TAG_WIDTH-1:0]  tag;
      logic                  illegal;
   } entry_t;

   logic                  ready_en;
   logic                  accept;
   logic                  s1_valid;
   logic [DATA_WIDTH-1:0] s1_a;
   logic [DATA_WIDTH-1:0] s1_b;
   opcode_e               s1_op;
   logic [TAG_WIDTH-1:0]  s1_tag;

   logic [DATA_WIDTH-1:0] add_x;
   logic [DATA_WIDTH-1:0] add_y;
   logic                  add_cin;
   logic                  is_arith;
   logic                  illegal_op;
   logic [DATA_WIDTH-1:0] logic_res;
   logic [DATA_WIDTH:0]   sum;
   logic                  ovf;
   logic [DATA_WIDTH-1:0] res;
   entry_t                alu_out;

   entry_t                mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  push;
   logic                  pop;
   entry_t                head;

   // Credits count both queued results and the one in flight in stage 1, so an
   // accepted request always finds a free FIFO slot when it arrives.
   assign in_ready = ready_en && ((count + CW'(s1_valid)) < CW'(FIFO_DEPTH));
   assign accept   = in_valid && in_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
         s1_valid <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         s1_valid <= accept;
      end
   end

   // NOTE: payload registers carry no reset; their contents are only consumed
   // when the matching valid bit is set, which is reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_a   <= operand_a;
         s1_b   <= operand_b;
         s1_op  <= opcode_e'(opcode);
         s1_tag <= in_tag;
      end
   end

   // Subtracting forms are mapped onto one adder as x + ~y + 1.
   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      add_x      = s1_a;
      add_y      = '0;
      add_cin    = 1'b0;
      is_arith   = 1'b0;
      illegal_op = 1'b0;
      logic_res  = '0;
      case (s1_op)
         OP_ADD: begin is_arith = 1'b1; add_y = s1_b; end
         OP_SUB: begin is_arith = 1'b1; add_y = ~s1_b; add_cin = 1'b1; end
         OP_INC: begin is_arith = 1'b1; add_cin = 1'b1; end
         OP_DEC: begin is_arith = 1'b1; add_y = ~ONE; add_cin = 1'b1; end
         OP_NEG: begin is_arith = 1'b1; add_x = '0; add_y = ~s1_a; add_cin = 1'b1; end
         OP_AND: logic_res = s1_a & s1_b;
         OP_OR:  logic_res = s1_a | s1_b;
         OP_XOR: logic_res = s1_a ^ s1_b;
         OP_NOT: logic_res = ~s1_a;
         OP_SHL: logic_res = s1_a << s1_b[SHW-1:0];
         OP_SHR: logic_res = s1_a >> s1_b[SHW-1:0];
         OP_SRA: logic_res = $signed(s1_a) >>> s1_b[SHW-1:0];
         default: illegal_op = 1'b1;
      endcase
   end

   assign sum = {1'b0, add_x} + {1'b0, add_y} + {{DATA_WIDTH{1'b0}}, add_cin};
   assign ovf = (add_x[DATA_WIDTH-1] == add_y[DATA_WIDTH-1]) &&
                (sum[DATA_WIDTH-1] != add_x[DATA_WIDTH-1]);
   assign res = is_arith ? sum[DATA_WIDTH-1:0] : logic_res;

   always_comb begin
      alu_out     = '0;
      alu_out.tag = s1_tag;
      if (illegal_op) begin
         alu_out.flags   = 4'b0001;
         alu_out.illegal = 1'b1;
      end else begin
         alu_out.result = res;
         alu_out.flags  = {is_arith & sum[DATA_WIDTH], is_arith & ovf,
                           res[DATA_WIDTH-1], res == '0};
      end
   end

   assign push = s1_valid;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= alu_out;
   end

   // Pointers are exactly PW bits wide, so wrap modulo FIFO_DEPTH is free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign out_valid = (count != '0);
   assign head      = out_valid ? mem[rd_ptr] : '0;
   assign result    = head.result;
   assign flags     = head.flags;
   assign out_tag   = head.tag;
   assign illegal   = head.illegal;

endmodule

// File: tb/tb_pipelined_alu_bank.sv
// Scoreboard bench for pipelined_alu_bank: the driver queues hand-computed
// expectations on acceptance, and a monitor compares every popped result.
module tb_pipelined_alu_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [5:0]  opcode;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  flags;
   logic [3:0]  out_tag;
   logic        illegal;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  fl;
      logic [3:0]  tag;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_pops   = 0;

   pipelined_alu_bank #(.DATA_WIDTH(32), .TAG_WIDTH(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .operand_a(operand_a), .operand_b(operand_b),
      .opcode(opcode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags), .out_tag(out_tag), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare on every cycle in which the head is actually popped.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", out_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               n_pops++;
               check($sformatf("result_tag%0d", e.tag), result, e.res);
               check($sformatf("flags_tag%0d", e.tag), flags, e.fl);
               check($sformatf("out_tag_exp%0d", e.tag), out_tag, e.tag);
               check($sformatf("illegal_tag%0d", e.tag), illegal, e.ill);
            end
         end
      end
   end

   task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
      in_valid  = 1'b1;
      opcode    = op;
      operand_a = a;
      operand_b = b;
      in_tag    = tag;
   endtask

   // Holds the request until accepted (bounded), then returns at posedge+1.
   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] eres,
                        input logic [3:0] efl, input logic eill);
      int waits = 0;
      drive(op, a, b, tag);
      @(negedge clk);
      while (!in_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (in_ready) sb.push_back('{res: eres, fl: efl, tag: tag, ill: eill});
      else check("accept_timeout", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(posedge clk);
         w++;
      end
      check(name, sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int accepted;
      int pops0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      operand_a = '0;
      operand_b = '0;
      opcode    = '0;
      in_tag    = '0;
      out_ready = 1'b0;

      #12;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_result", result, 32'h0);
      check("rst_flags", flags, 4'h0);
      check("rst_out_tag", out_tag, 4'h0);
      check("rst_illegal", illegal, 1'b0);
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("ready_after_rst", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Latency: result visible two edges after acceptance.
      out_ready = 1'b1;
      issue(6'b000000, 32'hFFFF_FFFF, 32'h1, 4'd3, 32'h0, 4'b1001, 1'b0);
      @(negedge clk);
      check("lat_edge1_valid", out_valid, 1'b0);
      @(negedge clk);
      check("lat_edge2_valid", out_valid, 1'b1);
      wait_drain("drain_latency");

      // Directed ALU vectors, issued back to back.
      issue(6'b000001, 32'h8000_0000, 32'h1,         4'd0,  32'h7FFF_FFFF, 4'b1100, 1'b0);
      issue(6'b000001, 32'h5,         32'h7,         4'd1,  32'hFFFF_FFFE, 4'b0010, 1'b0);
      issue(6'b010110, 32'h8000_0000, 32'd31,        4'd2,  32'hFFFF_FFFF, 4'b0010, 1'b0);
      issue(6'b100000, 32'h1234_5678, 32'h1,         4'd3,  32'h0,         4'b0001, 1'b1);
      issue(6'b000000, 32'h7FFF_FFFF, 32'h1,         4'd4,  32'h8000_0000, 4'b0110, 1'b0);
      issue(6'b000001, 32'h5,         32'h5,         4'd5,  32'h0,         4'b1001, 1'b0);
      issue(6'b000010, 32'h7FFF_FFFF, 32'h0,         4'd6,  32'h8000_0000, 4'b0110, 1'b0);
      issue(6'b000011, 32'h0,         32'h0,         4'd7,  32'hFFFF_FFFF, 4'b0010, 1'b0);
      issue(6'b000100, 32'h0,         32'h0,         4'd8,  32'h0,         4'b1001, 1'b0);
      issue(6'b000100, 32'h8000_0000, 32'h0,         4'd9,  32'h8000_0000, 4'b0110, 1'b0);
      issue(6'b010000, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd10, 32'hF000_F000, 4'b0010, 1'b0);
      issue(6'b010001, 32'h0,         32'h0,         4'd11, 32'h0,         4'b0001, 1'b0);
      issue(6'b010010, 32'hAAAA_AAAA, 32'h5555_5555, 4'd12, 32'hFFFF_FFFF, 4'b0010, 1'b0);
      issue(6'b010011, 32'h0,         32'h0,         4'd13, 32'hFFFF_FFFF, 4'b0010, 1'b0);
      issue(6'b010100, 32'h1,         32'd33,        4'd14, 32'h2,         4'b0000, 1'b0);
      issue(6'b010101, 32'h8000_0000, 32'd4,         4'd15, 32'h0800_0000, 4'b0000, 1'b0);
      issue(6'b000101, 32'h1,         32'h1,         4'd0,  32'h0,         4'b0001, 1'b1);
      issue(6'b010111, 32'h1,         32'h1,         4'd1,  32'h0,         4'b0001, 1'b1);
      wait_drain("drain_vectors");

      // Back-pressure: six back-to-back requests, no retries, consumer stalled.
      out_ready = 1'b0;
      accepted  = 0;
      for (int i = 0; i < 6; i++) begin
         drive(6'b000000, 32'(i), 32'h1, 4'(i));
         @(negedge clk);
         if (in_ready) begin
            accepted++;
            sb.push_back('{res: 32'(i + 1), fl: 4'b0000, tag: 4'(i), ill: 1'b0});
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("bp_accepted", accepted, 4);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("bp_in_ready_low", in_ready, 1'b0);
         check("bp_head_tag_hold", out_tag, 4'd0);
         check("bp_head_result_hold", result, 32'h1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_pop_per_cycle", out_valid, 1'b1);
      end
      @(negedge clk);
      check("bp_empty_after", out_valid, 1'b0);
      wait_drain("drain_bp");

      // Throughput: continuous requests with the consumer always ready.
      pops0 = n_pops;
      for (int i = 0; i < 8; i++) begin
         drive(6'b000000, 32'(i), 32'h100, 4'(i + 8));
         @(negedge clk);
         check("tp_in_ready", in_ready, 1'b1);
         if (in_ready) sb.push_back('{res: 32'h100 + 32'(i), fl: 4'b0000, tag: 4'(i + 8), ill: 1'b0});
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("tp_one_left", sb.size(), 1);
      wait_drain("drain_tp");
      check("tp_pop_count", n_pops - pops0, 8);

      // Reset with three results queued: all must be discarded.
      out_ready = 1'b0;
      issue(6'b000000, 32'h10, 32'h1, 4'd1, 32'h11, 4'b0000, 1'b0);
      issue(6'b000000, 32'h20, 32'h1, 4'd2, 32'h21, 4'b0000, 1'b0);
      issue(6'b000000, 32'h30, 32'h1, 4'd3, 32'h31, 4'b0000, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_in_ready", in_ready, 1'b0);
      check("mid_rst_result", result, 32'h0);
      check("mid_rst_out_tag", out_tag, 4'h0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("mid_rst_ready_pre_edge", in_ready, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_stale_valid", out_valid, 1'b0);
      end
      check("ready_after_mid_rst", in_ready, 1'b1);
      @(posedge clk);
      #1;
      issue(6'b000000, 32'h2, 32'h3, 4'd9, 32'h5, 4'b0000, 1'b0);
      wait_drain("drain_post_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/pipelined_alu_bank.md
PIPELINED_ALU_BANK -- requirements
Module: pipelined_alu_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand/result width; legal values are powers of 2 from 8 to 64.
REQ-002 SHALL have parameter TAG_WIDTH, default 4, the width of the transaction tag carried with each operation.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the result queue depth; legal values are powers of 2, minimum 2.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  the request is valid.
REQ-007 SHALL have port in_ready  output  1  the block can accept a request.
REQ-008 SHALL have ports operand_a and operand_b  input  DATA_WIDTH  the source operands.
REQ-009 SHALL have port opcode  input  6  the operation code.
REQ-010 SHALL have port in_tag  input  TAG_WIDTH  the request tag.
REQ-011 SHALL have port out_valid  output  1  the result queue head is valid.
REQ-012 SHALL have port out_ready  input  1  the consumer accepts the head.
REQ-013 SHALL have port result  output  DATA_WIDTH  the head result.
REQ-014 SHALL have port flags  output  4  {Carry, Overflow, Sign, Zero} of the head.
REQ-015 SHALL have port out_tag  output  TAG_WIDTH  the head tag.
REQ-016 SHALL have port illegal  output  1  the head opcode was illegal.

Function
REQ-017 SHALL accept a request on a rising edge where in_valid && in_ready, capturing the operands, opcode and tag into the stage-1 register; at most one request is accepted per cycle.
REQ-018 SHALL compute the result combinationally from stage 1 and write {result, flags, tag, illegal} into the FIFO on the next edge; out_valid is high 2 edges after acceptance if the FIFO was empty (latency 2).
REQ-019 SHALL support arithmetic ops for opcode[5:4]=00: x0000 ADD a+b, x0001 SUB a-b, x0010 INC a+1, x0011 DEC a-1, x0100 NEG 0-a.
REQ-020 SHALL support logic ops for opcode[5:4]=01: x0000 AND, x0001 OR, x0010 XOR, x0011 NOT a, x0100 SHL a<<b[log2(DATA_WIDTH)-1:0], x0101 SHR logical, x0110 SRA arithmetic.
REQ-021 SHALL treat every other opcode as illegal: result=0, flags=4'b0001, illegal=1; an illegal op is still queued and still consumes a slot.
REQ-022 SHALL compute all arithmetic modulo 2^DATA_WIDTH; SUB, DEC and NEG are computed as x + ~y + 1.
REQ-023 SHALL set Carry to the carry-out of the DATA_WIDTH-bit addition; for SUB this means Carry=1 iff a>=b unsigned.
REQ-024 SHALL set Overflow to the two's-complement signed overflow of the operation.
REQ-025 SHALL clear Carry and Overflow for logic ops.
REQ-026 SHALL set Sign to result[MSB] and Zero to (result==0) for all legal ops.
REQ-027 SHALL drive in_ready = (fifo_count + stage1_valid) < FIFO_DEPTH, so that no accepted request can ever be dropped; in_ready is independent of in_valid.
REQ-028 SHALL present the FIFO head on result, flags, out_tag and illegal; these outputs hold stable while out_valid && !out_ready; a pop occurs on out_valid && out_ready.
REQ-029 SHALL deliver results in acceptance order, with no reordering.
REQ-030 SHALL handle a simultaneous push and pop on a full FIFO without loss; fifo_count is unchanged.
REQ-031 SHALL handle a simultaneous accept and pop in the same cycle when the credit count is FIFO_DEPTH-1 or less.
REQ-032 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-033 SHALL keep out_valid low when the FIFO is empty and ignore out_ready while out_valid is low.

Reset
REQ-034 SHALL, on rst_n low, asynchronously clear stage1_valid, the FIFO pointers and fifo_count, and drive out_valid=0, result=0, flags=0, out_tag=0, illegal=0 and in_ready=0.
REQ-035 SHALL drive in_ready=1 from the first edge after rst_n deasserts.
REQ-036 SHALL discard all in-flight and queued operations when reset is asserted mid-operation; none of them are output afterwards.

Verification
REQ-037 Bench SHALL cover: ADD 0xFFFFFFFF+0x1 tag 3 -> after 2 cycles result=0, flags=4'b1001, out_tag=3.
REQ-038 Bench SHALL cover: SUB 0x80000000-0x1 -> result=0x7FFFFFFF, flags=4'b1100; SUB 0x5-0x7 -> result=0xFFFFFFFE, flags=4'b0010.
REQ-039 Bench SHALL cover: SRA 0x80000000 by 31 -> 0xFFFFFFFF, flags=4'b0010; opcode 6'b100000 -> result=0, illegal=1, flags=4'b0001.
REQ-040 Bench SHALL cover: out_ready=0 while issuing 6 back-to-back requests -> exactly 4 accepted, in_ready low thereafter; then release out_ready -> tags emerge in order with one pop per cycle.
REQ-041 Bench SHALL cover: continuous in_valid and out_ready -> throughput of 1 per cycle with in_ready constantly high.
REQ-042 Bench SHALL cover: assert rst_n low with 3 ops queued -> out_valid=0 immediately; after release, no stale results appear.
